// File: rtl/ham_pkg.sv
// ham_pkg: shared constants and elaboration-time helpers for the SECDED codec.
package ham_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    function automatic int ham_r(input int data_w);
        int r = 1;
        while ((1 << r) < data_w + r + 1) r++;
        return r;
    endfunction

    function automatic logic is_pow2(input int pos);
        return pos > 0 && (pos & (pos - 1)) == 0;
    endfunction

    // Hamming position (1-based) that holds data bit k.
    function automatic int data_pos(input int k);
        int n = 0;
        int pos = 0;
        for (int p = 3; p < 80; p++)
            if (!is_pow2(p)) begin
                if (n == k) pos = p;
                n++;
            end
        return pos;
    endfunction

endpackage

// File: rtl/ham_secded_core.sv
// ham_secded_core: combinational extended-Hamming encoder and syndrome/parity/data extractor.
module ham_secded_core import ham_pkg::*; #(
    parameter  int DATA_W = 4,
    localparam int R      = ham_r(DATA_W),
    localparam int CODE_W = DATA_W + R + 1
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [CODE_W-1:0] code_i,
    output logic [CODE_W-1:0] code_o,
    output logic [R-1:0]      syn_o,
    output logic              par_o,
    output logic [DATA_W-1:0] data_o
);

    logic [CODE_W-2:0] dmap;
    logic [CODE_W-2:0] pmap;
    logic [R-1:0]      enc_syn;

    for (genvar p = 1; p < CODE_W; p++) begin : g_pos
        if (is_pow2(p)) begin : g_par
            assign dmap[p-1] = 1'b0;
            assign pmap[p-1] = enc_syn[$clog2(p)];
        end else begin : g_dat
            assign pmap[p-1] = 1'b0;
        end
    end

    for (genvar k = 0; k < DATA_W; k++) begin : g_data
        assign dmap[data_pos(k)-1] = data_i[k];
        assign data_o[k]           = code_i[data_pos(k)-1];
    end

    // Parity bits equal the syndrome of the data-only word.
    always_comb begin
        enc_syn = '0;
        syn_o   = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (dmap[i-1]) enc_syn = enc_syn ^ R'(i);
            if (code_i[i-1]) syn_o = syn_o ^ R'(i);
        end
    end

    assign code_o = {^(dmap | pmap), dmap | pmap};
    assign par_o  = ^code_i;

endmodule

// File: rtl/ham_secded_pipe.sv
// ham_secded_pipe: two-stage valid/ready SECDED encode/decode pipeline with saturating error counters.
module ham_secded_pipe import ham_pkg::*; #(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 16,
    localparam int R      = ham_r(DATA_W),
    localparam int CODE_W = DATA_W + R + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_data,
    output logic              out_corr,
    output logic              out_uncorr,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    logic [CODE_W-1:0] enc_code;
    logic [R-1:0]      syn;
    logic              par;
    logic [DATA_W-1:0] ext_data;

    ham_secded_core #(.DATA_W(DATA_W)) u_core (
        .data_i (in_data[DATA_W-1:0]),
        .code_i (in_data),
        .code_o (enc_code),
        .syn_o  (syn),
        .par_o  (par),
        .data_o (ext_data)
    );

    logic              s1_valid_q, s1_valid_d, s1_mode_q, s1_par_q;
    logic [CODE_W-1:0] s1_word_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [R-1:0]      s1_syn_q;
    logic              s2_valid_q, s2_valid_d, s2_corr_q, s2_corr_d, s2_uncorr_q, s2_uncorr_d;
    logic [CODE_W-1:0] s2_data_q, s2_data_d;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d, uncorr_cnt_q, uncorr_cnt_d;
    logic              s1_load, s2_load, s2_move, dec_corr, dec_uncorr;
    logic [DATA_W-1:0] flip;

    assign s2_move    = s2_valid_q && out_ready;
    assign s2_load    = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_load;
    assign s1_load    = in_valid && in_ready;
    assign s1_valid_d = in_ready ? in_valid : s1_valid_q;
    assign s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;

    // Syndromes past the last real position belong to the shortened part of the code.
    assign dec_corr   = s1_par_q && int'(s1_syn_q) < CODE_W;
    assign dec_uncorr = s1_syn_q != '0 && !dec_corr;

    for (genvar k = 0; k < DATA_W; k++) begin : g_flip
        assign flip[k] = dec_corr && s1_syn_q == R'(data_pos(k));
    end

    always_comb begin
        s2_data_d   = s2_data_q;
        s2_corr_d   = s2_corr_q;
        s2_uncorr_d = s2_uncorr_q;
        if (s2_load && s1_valid_q) begin
            s2_data_d   = (s1_mode_q == MODE_DEC) ? CODE_W'(s1_data_q ^ flip) : s1_word_q;
            s2_corr_d   = (s1_mode_q == MODE_DEC) && dec_corr;
            s2_uncorr_d = (s1_mode_q == MODE_DEC) && dec_uncorr;
        end
    end

    always_comb begin
        corr_cnt_d   = cnt_clr ? '0 :
                       (s2_move && s2_corr_q && corr_cnt_q != '1) ? corr_cnt_q + 1'b1 : corr_cnt_q;
        uncorr_cnt_d = cnt_clr ? '0 :
                       (s2_move && s2_uncorr_q && uncorr_cnt_q != '1) ? uncorr_cnt_q + 1'b1 : uncorr_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_ENC;
            s1_word_q  <= '0;
            s1_data_q  <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                s1_mode_q <= in_mode;
                s1_word_q <= (in_mode == MODE_DEC) ? in_data : enc_code;
                s1_data_q <= ext_data;
                s1_syn_q  <= syn;
                s1_par_q  <= par;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_corr_q    <= 1'b0;
            s2_uncorr_q  <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_corr_q    <= s2_corr_d;
            s2_uncorr_q  <= s2_uncorr_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_corr   = s2_corr_q;
    assign out_uncorr = s2_uncorr_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_ham_secded_pipe.sv
// tb_ham_secded_pipe: scoreboard bench for the SECDED pipeline at DATA_W=4 and DATA_W=11.
module tb_ham_secded_pipe;
    import ham_pkg::*;

    typedef struct {
        logic        mode;
        logic [15:0] din;
        logic [15:0] data;
        logic        corr;
        logic        uncorr;
    } beat_t;

    logic        clk = 0;
    logic        reset_n = 0;
    logic        in_valid = 0, in_ready, in_mode = 0, out_valid, out_ready = 1;
    logic [7:0]  in_data = 0, out_data;
    logic        out_corr, out_uncorr, cnt_clr = 0;
    logic [1:0]  corr_cnt, uncorr_cnt;
    logic        w_in_valid = 0, w_in_ready, w_in_mode = 0, w_out_valid, w_out_ready = 1;
    logic [15:0] w_in_data = 0, w_out_data;
    logic        w_out_corr, w_out_uncorr;
    logic [15:0] w_corr_cnt, w_uncorr_cnt;

    beat_t pend[$];
    beat_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    ham_secded_pipe #(.DATA_W(4), .CNT_W(2)) u4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_corr(out_corr), .out_uncorr(out_uncorr), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt),
        .uncorr_cnt(uncorr_cnt)
    );

    ham_secded_pipe #(.DATA_W(11), .CNT_W(16)) u11 (
        .clk(clk), .reset_n(reset_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_mode(w_in_mode),
        .in_data(w_in_data), .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .out_corr(w_out_corr), .out_uncorr(w_out_uncorr), .cnt_clr(1'b0), .corr_cnt(w_corr_cnt),
        .uncorr_cnt(w_uncorr_cnt)
    );

    function automatic logic [15:0] model_enc(input logic [15:0] d, input int cw);
        logic [15:0] c;
        logic        b;
        int          j;
        c = '0;
        j = 0;
        for (int pos = 1; pos < cw; pos++)
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[j];
                j++;
            end
        for (int i = 0; (1 << i) < cw; i++) begin
            b = 1'b0;
            for (int pos = 1; pos < cw; pos++)
                if (((pos >> i) & 1) == 1) b ^= c[pos-1];
            c[(1 << i) - 1] = b;
        end
        c[cw-1] = ^c;
        return c;
    endfunction

    task automatic add(input logic mode, input logic [15:0] din, input logic [15:0] data,
                       input logic corr, input logic uncorr);
        pend.push_back('{mode, din, data, corr, uncorr});
    endtask

    task automatic drive_u4();
        in_valid = pend.size() != 0;
        if (in_valid) begin
            in_mode = pend[0].mode;
            in_data = pend[0].din[7:0];
        end
    endtask

    task automatic take_u4();
        if (in_valid && in_ready) begin
            sb.push_back(pend[0]);
            pend.delete(0);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset_n = 1;
        #1;
        vectors++;
        if ({out_valid, in_ready, out_data, out_corr, out_uncorr, corr_cnt, uncorr_cnt} !== {1'b0, 1'b1, 8'h00, 6'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b ready=%b data=%h corr=%b uncorr=%b cc=%0d uc=%0d, want 0 1 00 0 0 0 0",
                     out_valid, in_ready, out_data, out_corr, out_uncorr, corr_cnt, uncorr_cnt);
        end
    endtask

    task automatic test_encode();
        @(negedge clk);
        in_valid = 1; in_mode = MODE_ENC; in_data = 8'h0B; out_ready = 1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL enc_accept: in_ready=%b, want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL enc_early: out_valid=%b one edge after accept, want 0", out_valid);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({out_valid, out_data, out_corr, out_uncorr} !== {1'b1, 8'h55, 2'b00}) begin
            miscompares++;
            $display("FAIL enc_0b: got valid=%b data=%h corr=%b uncorr=%b, want 1 55 0 0",
                     out_valid, out_data, out_corr, out_uncorr);
        end
    endtask

    task automatic test_decode();
        int cyc = 0;
        add(MODE_DEC, 16'h55, 16'h0B, 0, 0);
        add(MODE_DEC, 16'h51, 16'h0B, 1, 0);
        add(MODE_DEC, 16'hD5, 16'h0B, 1, 0);
        add(MODE_DEC, 16'h56, 16'h0B, 0, 1);
        add(MODE_ENC, 16'hA3, model_enc(16'h3, 8), 0, 0);
        while ((pend.size() != 0 || sb.size() != 0) && cyc < 100) begin
            @(negedge clk);
            out_ready = 1;
            drive_u4();
            #1;
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0 || {out_data, out_corr, out_uncorr} !== {sb[0].data[7:0], sb[0].corr, sb[0].uncorr}) begin
                    miscompares++;
                    $display("FAIL decode_beat: got data=%h corr=%b uncorr=%b, want data=%h corr=%b uncorr=%b",
                             out_data, out_corr, out_uncorr, sb[0].data[7:0], sb[0].corr, sb[0].uncorr);
                end
                if (sb.size() != 0) sb.delete(0);
            end
            take_u4();
            cyc++;
        end
        in_valid = 0;
        vectors++;
        if (cyc >= 100) begin
            miscompares++;
            $display("FAIL decode_timeout: %0d beats outstanding, want 0", pend.size() + sb.size());
            pend.delete(); sb.delete();
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({corr_cnt, uncorr_cnt} !== {2'd2, 2'd1}) begin
            miscompares++;
            $display("FAIL decode_counts: got corr=%0d uncorr=%0d, want 2 1", corr_cnt, uncorr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        @(negedge clk);
        cnt_clr = 1;
        @(negedge clk);
        cnt_clr = 0;
        #1;
        vectors++;
        if ({corr_cnt, uncorr_cnt} !== 4'b0) begin
            miscompares++;
            $display("FAIL cnt_clear: got corr=%0d uncorr=%0d, want 0 0", corr_cnt, uncorr_cnt);
        end
        repeat (5) add(MODE_DEC, 16'h51, 16'h0B, 1, 0);
        while ((pend.size() != 0 || sb.size() != 0) && cyc < 100) begin
            @(negedge clk);
            out_ready = 1;
            drive_u4();
            #1;
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0 || {out_data, out_corr, out_uncorr} !== {sb[0].data[7:0], sb[0].corr, sb[0].uncorr}) begin
                    miscompares++;
                    $display("FAIL b2b_beat: got data=%h corr=%b uncorr=%b, want data=%h corr=%b uncorr=%b",
                             out_data, out_corr, out_uncorr, sb[0].data[7:0], sb[0].corr, sb[0].uncorr);
                end
                if (sb.size() != 0) sb.delete(0);
            end
            take_u4();
            cyc++;
        end
        in_valid = 0;
        vectors++;
        if (cyc !== 7) begin
            miscompares++;
            $display("FAIL b2b_throughput: drained in %0d cycles, want 7", cyc);
            pend.delete(); sb.delete();
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({corr_cnt, uncorr_cnt} !== {2'd3, 2'd0}) begin
            miscompares++;
            $display("FAIL cnt_saturate: got corr=%0d uncorr=%0d, want 3 0", corr_cnt, uncorr_cnt);
        end
        in_valid = 1; in_mode = MODE_DEC; in_data = 8'h51;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        #1;
        vectors++;
        if ({out_valid, out_corr} !== 2'b11) begin
            miscompares++;
            $display("FAIL sixth_beat: got valid=%b corr=%b, want 1 1", out_valid, out_corr);
        end
        cnt_clr = 1;
        @(negedge clk);
        cnt_clr = 0;
        #1;
        vectors++;
        if ({corr_cnt, out_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL clr_with_inc: got corr=%0d valid=%b, want 0 0", corr_cnt, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int          cyc = 0;
        int          f;
        logic [15:0] x;
        logic        blocked = 0;
        for (int i = 0; i < 8; i++) begin
            x = 16'($urandom_range(0, 15));
            f = $urandom_range(0, 8);
            if (i % 2 == 0) add(MODE_ENC, x | 16'hF0, model_enc(x, 8), 0, 0);
            else add(MODE_DEC, model_enc(x, 8) ^ (16'h1 << f), x, f < 8, 0);
        end
        while ((pend.size() != 0 || sb.size() != 0) && cyc < 200) begin
            @(negedge clk);
            out_ready = (cyc % 2 == 0);
            drive_u4();
            #1;
            vectors++;
            if (in_ready !== !(sb.size() == 2 && !out_ready)) begin
                miscompares++;
                $display("FAIL bp_in_ready: got %b with %0d in flight out_ready=%b", in_ready, sb.size(), out_ready);
            end
            if (!in_ready) blocked = 1;
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0 || {out_data, out_corr, out_uncorr} !== {sb[0].data[7:0], sb[0].corr, sb[0].uncorr}) begin
                    miscompares++;
                    $display("FAIL bp_beat: got data=%h corr=%b uncorr=%b, want data=%h corr=%b uncorr=%b",
                             out_data, out_corr, out_uncorr, sb[0].data[7:0], sb[0].corr, sb[0].uncorr);
                end
                if (sb.size() != 0) sb.delete(0);
            end
            take_u4();
            cyc++;
        end
        in_valid = 0;
        vectors++;
        if (cyc >= 200 || !blocked) begin
            miscompares++;
            $display("FAIL bp_drain: outstanding=%0d blocked=%b, want 0 1", pend.size() + sb.size(), blocked);
            pend.delete(); sb.delete();
        end
    endtask

    task automatic test_reset_flush();
        logic stale = 0;
        @(negedge clk);
        out_ready = 0; in_valid = 1; in_mode = MODE_ENC; in_data = 8'h05;
        @(negedge clk);
        in_data = 8'h0A;
        @(negedge clk);
        in_valid = 0;
        #1;
        vectors++;
        if ({out_valid, in_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL flush_inflight: got valid=%b ready=%b, want 1 0", out_valid, in_ready);
        end
        reset_n = 0;
        #1;
        vectors++;
        if ({out_valid, in_ready, out_data, corr_cnt, uncorr_cnt} !== {1'b0, 1'b1, 8'h00, 4'b0}) begin
            miscompares++;
            $display("FAIL flush_reset: got valid=%b ready=%b data=%h cc=%0d uc=%0d, want 0 1 00 0 0",
                     out_valid, in_ready, out_data, corr_cnt, uncorr_cnt);
        end
        @(negedge clk);
        reset_n = 1;
        out_ready = 1;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (out_valid) stale = 1;
        end
        vectors++;
        if (stale !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_stale: stale beat seen=%b, want 0", stale);
        end
    endtask

    task automatic test_wide();
        int          cyc = 0;
        int          f;
        logic [15:0] x;
        for (int i = 0; i < 12; i++) begin
            x = 16'($urandom_range(0, 2047));
            f = $urandom_range(0, 16);
            add(MODE_ENC, x, model_enc(x, 16), 0, 0);
            add(MODE_DEC, model_enc(x, 16) ^ (16'h1 << f), x, f < 16, 0);
        end
        while ((pend.size() != 0 || sb.size() != 0) && cyc < 300) begin
            @(negedge clk);
            w_out_ready = 1;
            w_in_valid = pend.size() != 0;
            if (w_in_valid) begin
                w_in_mode = pend[0].mode;
                w_in_data = pend[0].din;
            end
            #1;
            if (w_out_valid && w_out_ready) begin
                vectors++;
                if (sb.size() == 0 || {w_out_data, w_out_corr, w_out_uncorr} !== {sb[0].data, sb[0].corr, sb[0].uncorr}) begin
                    miscompares++;
                    $display("FAIL w11_beat: got data=%h corr=%b uncorr=%b, want data=%h corr=%b uncorr=%b",
                             w_out_data, w_out_corr, w_out_uncorr, sb[0].data, sb[0].corr, sb[0].uncorr);
                end
                if (sb.size() != 0) sb.delete(0);
            end
            if (w_in_valid && w_in_ready) begin
                sb.push_back(pend[0]);
                pend.delete(0);
            end
            cyc++;
        end
        w_in_valid = 0;
        vectors++;
        if (cyc >= 300) begin
            miscompares++;
            $display("FAIL w11_timeout: %0d beats outstanding, want 0", pend.size() + sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_decode();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
